// File: rtl/inorder_alloc_issue_ctrl.sv
// inorder_alloc_issue_ctrl: in-order allocate/issue pointer, count and busy tracking
// for one reservation-station bank; up to REQ_MAX allocations and one issue per cycle.
module inorder_alloc_issue_ctrl #(
  parameter int ENT_SEL = 3,
  parameter int ENT_NUM = 8,
  parameter int REQ_MAX = 2,
  parameter int REQ_W   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [REQ_W-1:0]   req_num_i,
  input  logic               dp_stall_i,
  input  logic               dp_kill_i,
  input  logic [ENT_NUM-1:0] ready_vector_i,
  input  logic               issue_ack_i,
  output logic [ENT_SEL-1:0] alloc_ptr_o,
  output logic               allocatable_o,
  output logic [ENT_SEL-1:0] issue_ptr_o,
  output logic               issue_valid_o,
  output logic [ENT_NUM-1:0] busy_vector_o,
  output logic [ENT_SEL:0]   count_o,
  output logic               full_o,
  output logic               empty_o
);
  localparam int CW = ENT_SEL + 1;
  logic [ENT_SEL-1:0] r_head, r_tail;
  logic [CW-1:0]      r_count;
  logic [ENT_NUM-1:0] r_busy, w_set, w_clr;
  logic [31:0]        w_req, w_free;
  logic               w_alloc_fire, w_issue_fire;
  // Capacity uses the pre-issue count so issue_ack_i never reaches allocatable_o.
  assign w_req         = 32'(req_num_i);
  assign w_free        = 32'(ENT_NUM) - 32'(r_count);
  assign allocatable_o = reset_i && (w_req <= 32'(REQ_MAX)) && (w_free >= w_req);
  assign empty_o       = r_count == '0;
  assign full_o        = r_count == CW'(ENT_NUM);
  assign issue_valid_o = !empty_o && ready_vector_i[r_head];
  assign w_alloc_fire  = allocatable_o && !dp_stall_i && !dp_kill_i && (w_req != 0);
  assign w_issue_fire  = issue_valid_o && issue_ack_i && !dp_kill_i;
  assign w_clr         = w_issue_fire ? (ENT_NUM'(1) << r_head) : '0;
  assign alloc_ptr_o   = r_tail;
  assign issue_ptr_o   = r_head;
  assign busy_vector_o = r_busy;
  assign count_o       = r_count;
  always_comb begin
    w_set = '0;
    for (int k = 0; k < REQ_MAX; k++)
      if (w_alloc_fire && (32'(k) < w_req)) w_set[r_tail + ENT_SEL'(k)] = 1'b1;
  end
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_busy  <= '0;
    end else if (dp_kill_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_busy  <= '0;
    end else begin
      r_head  <= r_head + ENT_SEL'(w_issue_fire);
      r_tail  <= w_alloc_fire ? r_tail + ENT_SEL'(req_num_i) : r_tail;
      r_count <= r_count + (w_alloc_fire ? CW'(req_num_i) : CW'(0)) - CW'(w_issue_fire);
      r_busy  <= (r_busy | w_set) & ~w_clr;
    end
  end
endmodule
